// File: rtl/button_debouncer_pkg.sv
// Shared FSM encodings and 50 MHz board timing defaults for the button debouncer.
package button_debouncer_pkg;

  localparam logic [1:0] StIdle        = 2'd0;
  localparam logic [1:0] StPressWait   = 2'd1;
  localparam logic [1:0] StHeld        = 2'd2;
  localparam logic [1:0] StReleaseWait = 2'd3;

  localparam int unsigned DefaultDebounceCycles = 500000;
  localparam int unsigned DefaultRepeatDelay    = 25000000;
  localparam int unsigned DefaultRepeatPeriod   = 5000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit, with a synchronous active-low reset value.
module sync_2ff #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= ResetVal;
      s2_q <= ResetVal;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw push-button into a clean level plus press/release/auto-repeat strobes.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter int unsigned REPEAT_DELAY    = DefaultRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefaultRepeatPeriod
) (
  input  logic clk,
  input  logic btn_reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic push_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW   = $clog2(RptMax) + 1;

  localparam logic [CntW-1:0] CntLast      = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RptW-1:0] RptDelayLast = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RptPerLast   = RptW'(REPEAT_PERIOD - 1);

  logic            sync_q;
  logic            pressed;
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RptW-1:0] rcnt_q, rcnt_d;
  logic            rphase_q, rphase_d;
  logic            level_q, level_d;
  logic            push_q, push_d;
  logic            release_q, release_d;
  logic            repeat_q, repeat_d;

  sync_2ff #(
    .ResetVal (BTN_ACTIVE_LOW)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (btn_reset),
    .d_i    (btn_raw),
    .q_o    (sync_q)
  );

  assign pressed = sync_q ^ BTN_ACTIVE_LOW;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    rphase_d  = rphase_q;
    level_d   = level_q;
    push_d    = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pressed) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (!pressed) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d  = StHeld;
          cnt_d    = '0;
          push_d   = 1'b1;
          level_d  = 1'b1;
          rcnt_d   = '0;
          rphase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHeld: begin
        // Leaving HELD wins over a repeat due on the same edge.
        if (!pressed) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end else if (REPEAT_EN) begin
          if (rcnt_q == (rphase_q ? RptPerLast : RptDelayLast)) begin
            repeat_d = 1'b1;
            rcnt_d   = '0;
            rphase_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      StReleaseWait: begin
        if (pressed) begin
          state_d = StHeld;
        end else if (cnt_q == CntLast) begin
          state_d   = StIdle;
          cnt_d     = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!btn_reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      rphase_q  <= 1'b0;
      level_q   <= 1'b0;
      push_q    <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      rphase_q  <= rphase_d;
      level_q   <= level_d;
      push_q    <= push_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign btn_level     = level_q;
  assign push_pulse    = push_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = REPEAT_EN ? repeat_q : 1'b0;

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
Conditions one raw push-button input into clean, clock-synchronous control signals. It sits directly upstream of the adder and display stage, and replaces its ad-hoc 2-FF edge detect on btn_sum. It provides a two-flop synchroniser, a debounce state machine, and single-cycle press/release strobes. An optional auto-repeat strobe fires while the button is held.

Parameters:
DEBOUNCE_CYCLES, 500000, number of consecutive stable cycles needed to accept a level change (10 ms at 50 MHz); must be >= 1
BTN_ACTIVE_LOW, 1, 1 = btn_raw is low when pressed (board buttons); 0 = active-high
REPEAT_EN, 0, 1 = enable auto-repeat strobes while held
REPEAT_DELAY, 25000000, cycles from entering HELD to the first repeat strobe; must be >= 1
REPEAT_PERIOD, 5000000, cycles between later repeat strobes; must be >= 1

Ports:
clk  input  1  system clock; all logic on posedge
btn_reset  input  1  synchronous, active-low reset
btn_raw  input  1  asynchronous, bouncing button pin
btn_level  output  1  debounced pressed level (1 = pressed)
push_pulse  output  1  one-cycle strobe on an accepted press
release_pulse  output  1  one-cycle strobe on an accepted release
repeat_pulse  output  1  one-cycle auto-repeat strobe (tied 0 when REPEAT_EN=0)

Behaviour:
- Interface: one clock, clk. Reset is btn_reset, synchronous and active-low: sampled only on posedge clk, and btn_reset=0 resets the block.
- Reset values: state=IDLE, all counters 0, btn_level=0, push_pulse=0, release_pulse=0, repeat_pulse=0. Synchroniser flops load the inactive pin level (1 if BTN_ACTIVE_LOW, else 0).
- Synchroniser: two flops. pressed = sync2 XOR BTN_ACTIVE_LOW.
- Debounce counter: width = clog2(DEBOUNCE_CYCLES)+1. Repeat counter: width sized for max(REPEAT_DELAY, REPEAT_PERIOD).
- FSM states and transitions:
  - IDLE: if pressed -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT: if !pressed -> IDLE, cnt=0, no strobe. Else if cnt==DEBOUNCE_CYCLES-1 -> HELD, push_pulse=1 for one cycle, btn_level=1, rcnt=0. Else cnt+1.
  - HELD: if !pressed -> RELEASE_WAIT, cnt=0, rcnt frozen.
    - Else if REPEAT_EN: rcnt+1 each cycle. The first repeat_pulse fires REPEAT_DELAY edges after HELD entry. Later pulses fire every REPEAT_PERIOD edges.
  - RELEASE_WAIT: btn_level stays 1. If pressed -> HELD, with no push_pulse and rcnt resuming. Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE, release_pulse=1 for one cycle, btn_level=0. Else cnt+1.
- Latency: btn_raw goes to the pressed level before edge 1 and stays stable. FSM leaves IDLE at edge 3 and push_pulse is high after edge DEBOUNCE_CYCLES+3 for exactly one cycle. Release is symmetric: release_pulse follows DEBOUNCE_CYCLES+3 edges after a stable release.
- All outputs are registered; none depend combinationally on btn_raw.
- Strobes are mutually exclusive: at most one of push_pulse, release_pulse, repeat_pulse is high in any cycle. A repeat coinciding with the HELD->RELEASE_WAIT transition is suppressed.
- Glitches shorter than DEBOUNCE_CYCLES produce no strobe and no btn_level change.
- Reset mid-operation: returns to IDLE with outputs 0 the edge after btn_reset=0 is sampled. No release_pulse is generated. A button still held after reset releases must complete a full debounce and produces a fresh push_pulse.
- Counters saturate/clear as stated; no wrap-around is reachable.

Decomposition:
- Shared include/package: FSM state encodings (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; 2-bit) and board timing defaults (DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD for 50 MHz).
- One sub-module: sync_2ff (1-bit, parameterised reset value), reused for switch inputs elsewhere.

Test Plan:
All runs use DEBOUNCE_CYCLES=4, REPEAT_DELAY=6, REPEAT_PERIOD=3, BTN_ACTIVE_LOW=1.
1. Reset: btn_reset=0 for 3 edges with btn_raw toggling -> all outputs 0 throughout and on the first edge after release.
2. Clean press: btn_raw=0 from before edge 1 -> push_pulse=1 only after edge 7; btn_level=1 from edge 7 on; release_pulse=0 and repeat_pulse=0.
3. Press bounce: btn_raw low for 3 cycles then high -> no strobe, btn_level stays 0, FSM back in IDLE.
4. Auto-repeat: REPEAT_EN=1, held (HELD entered at edge 7) -> repeat_pulse after edges 13, 16, 19, 22; push_pulse only once.
5. Release: while held, a 2-cycle release glitch -> btn_level stays 1, no strobes. Then a stable release starting before edge R+1 -> release_pulse and btn_level=0 after edge R+7.
6. Reset mid-PRESS_WAIT with button held: btn_reset=0 at edge 5, released at edge 6 -> no strobe before edge 13; push_pulse after edge 13 (first post-reset sample at edge 7, +DEBOUNCE_CYCLES+2).
